ddr3_cache_arbiter: RTL
=======================

Name: ddr3_cache_arbiter

Overview:
- Shares the single-port DDR3 cache controller (32-bit word interface: addr/data/we/rd/ack) among three requesters: m0 instruction fetch, m1 CPU data, m2 DMA/VGA.
- Each requester holds its request until it receives a one-cycle ack.
- The arbiter latches one request and drives it to the cache controller until that controller acks.
- It then returns the registered read data and ack to the winning master.
- It also absorbs the controller's post-reset calibration ack so that ack never reaches a master.

Parameters:
- ADDR_WIDTH, 32, byte address width passed through to the controller.
- SKIP_INIT, 0, 1 = start in S_IDLE instead of waiting for the controller's calibration ack (simulation only).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- m0_addr_i, m1_addr_i, m2_addr_i  in  ADDR_WIDTH each  master byte addresses.
- m0_data_i, m1_data_i, m2_data_i  in  32 each  master write data.
- m0_data_o, m1_data_o, m2_data_o  out  32 each  registered read data, valid with the matching ack.
- m0_we_i, m1_we_i, m2_we_i  in  1 each  write request.
- m0_rd_i, m1_rd_i, m2_rd_i  in  1 each  read request.
- m0_ack_o, m1_ack_o, m2_ack_o  out  1 each  one-cycle completion pulse.
- ctrl_addr_o  out  ADDR_WIDTH  address to the cache controller.
- ctrl_data_o  out  32  write data to the controller.
- ctrl_data_i  in  32  read data from the controller (combinational, valid while ctrl_ack_i).
- ctrl_we_o  out  1  write strobe to the controller.
- ctrl_rd_o  out  1  read strobe to the controller.
- ctrl_ack_i  in  1  controller completion.
- grant_o  out  3  one-hot current owner, zero when idle (debug/LED).
- busy_o  out  1  high in S_ISSUE or S_RESP.

Behaviour:
- Reset: all outputs registered and zero. State is S_INIT, or S_IDLE when SKIP_INIT=1. Round-robin pointer last=2, so m0 is first in line.
- A master requests when we_i|rd_i. If both are set, it is a write and ctrl_rd_o stays 0.
- Masters must hold addr/data/we/rd stable until their ack. The arbiter samples them only in S_IDLE.
- S_INIT:
  - ctrl_we_o = ctrl_rd_o = 0.
  - The first ctrl_ack_i (calibration-done pulse from the controller) moves the state to S_IDLE.
  - Master requests are ignored and no master ack is produced.
- S_IDLE:
  - If any request is pending, select a winner and latch its addr, wdata and op into ctrl_*. Set the ctrl_we_o/ctrl_rd_o registers, set grant_o one-hot, go to S_ISSUE.
  - Strobes appear the cycle after the request is sampled.
  - ctrl_ack_i in S_IDLE is ignored.
- S_ISSUE:
  - Hold ctrl_* constant.
  - On ctrl_ack_i: capture ctrl_data_i into the winner's mN_data_o (writes capture too; the value is don't-care). Pulse the winner's mN_ack_o the next cycle. Clear ctrl_we_o/ctrl_rd_o on the same edge, so the controller's following idle cycle sees no request. Go to S_RESP.
  - No timeout.
- S_RESP:
  - mN_ack_o = 1 for exactly this cycle. grant_o is still valid.
  - Next state S_IDLE with grant_o cleared. The acked master must drop its request by the end of this cycle.
- Minimum turnaround: request sampled at cycle T, controller ack at A ≥ T+2, master ack at A+1, next arbitration at A+2.
- Winner selection:
  - Round-robin: search order last+1, last+2, last (mod 3).
  - last updates to the winner when leaving S_IDLE.
- mN_data_o holds its value until the next ack to that master.
- The controller's ack is never forwarded to a non-granted master. A ctrl_ack_i arriving outside S_INIT/S_ISSUE is dropped.
- rst asserted mid-transaction: the arbiter returns to its reset state at once and no pending ack is delivered. The controller shares rst and re-initialises, and its new calibration ack is absorbed in S_INIT.

Optional Feature:
- DDR3_ARB_ROUND_ROBIN_EN
  - Defined: round-robin selection as above.
  - Undefined: fixed priority m0 > m1 > m2, the last register is removed, and m2 can starve under continuous m0/m1 traffic.

Test Plan:
- Reset, then the controller model acks once after 5 cycles; m1_rd_i is held high throughout -> no m1_ack_o before calibration; ctrl_rd_o rises 2 cycles after the calibration ack.
- m0 read addr 0x0000_0040, model acks after 4 cycles with 0xCAFEBABE -> m0_data_o=0xCAFEBABE, m0_ack_o high exactly 1 cycle, ctrl_rd_o low the cycle after ctrl_ack_i.
- m1 write addr 0x0000_1004, data 0x12345678 -> ctrl_we_o=1, ctrl_addr_o=0x1004, ctrl_data_o=0x12345678 held stable until ack; m1_ack_o 1 cycle later.
- m0, m1 and m2 all request continuously with round-robin enabled -> grant order m0, m1, m2, m0; each master's ack count is 2 after 6 transactions.
- m1_we_i=m1_rd_i=1 -> treated as a write (ctrl_we_o=1, ctrl_rd_o=0).
- rst pulsed during S_ISSUE of an m2 read -> no m2_ack_o, grant_o=0, and the arbiter waits for a new calibration ack before serving m2 again.

Source files
------------

// File: rtl/ddr3_cache_arbiter.sv
// Three-master arbiter in front of the single-port DDR3 cache controller; absorbs the calibration ack.
// Define DDR3_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority m0 > m1 > m2.
module ddr3_cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter bit SKIP_INIT  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [ADDR_WIDTH-1:0] m2_addr_i,
    input  logic [31:0]           m0_data_i,
    input  logic [31:0]           m1_data_i,
    input  logic [31:0]           m2_data_i,
    output logic [31:0]           m0_data_o,
    output logic [31:0]           m1_data_o,
    output logic [31:0]           m2_data_o,
    input  logic                  m0_we_i,
    input  logic                  m1_we_i,
    input  logic                  m2_we_i,
    input  logic                  m0_rd_i,
    input  logic                  m1_rd_i,
    input  logic                  m2_rd_i,
    output logic                  m0_ack_o,
    output logic                  m1_ack_o,
    output logic                  m2_ack_o,
    output logic [ADDR_WIDTH-1:0] ctrl_addr_o,
    output logic [31:0]           ctrl_data_o,
    input  logic [31:0]           ctrl_data_i,
    output logic                  ctrl_we_o,
    output logic                  ctrl_rd_o,
    input  logic                  ctrl_ack_i,
    output logic [2:0]            grant_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_RESP} state_t;

    state_t                  state;
    state_t                  next_state;
    logic [2:0]              req;
    logic                    any_req;
    logic [1:0]              win_idx;
    logic [2:0]              win;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [31:0]             win_data;
    logic                    win_we;
    logic                    win_rd;

    assign req     = {m2_we_i | m2_rd_i, m1_we_i | m1_rd_i, m0_we_i | m0_rd_i};
    assign any_req = |req;
    assign win     = any_req ? (3'b001 << win_idx) : 3'b000;
    assign busy_o  = (state == S_ISSUE) || (state == S_RESP);

`ifdef DDR3_ARB_ROUND_ROBIN_EN
    logic [1:0] last;
    logic [1:0] first_idx;
    logic [1:0] second_idx;
    logic [1:0] third_idx;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        first_idx  = 2'd0;
        second_idx = 2'd1;
        third_idx  = 2'd2;
        case (last)
            2'd0: begin first_idx = 2'd1; second_idx = 2'd2; third_idx = 2'd0; end
            2'd1: begin first_idx = 2'd2; second_idx = 2'd0; third_idx = 2'd1; end
            default: ;
        endcase
        if (req[first_idx])       win_idx = first_idx;
        else if (req[second_idx]) win_idx = second_idx;
        else                      win_idx = third_idx;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last <= 2'd2;
        else if (state == S_IDLE && any_req)
            last <= win_idx;
    end
`else
    always_comb begin
        if (req[0])      win_idx = 2'd0;
        else if (req[1]) win_idx = 2'd1;
        else             win_idx = 2'd2;
    end
`endif

    always_comb begin
        win_addr = m2_addr_i;
        win_data = m2_data_i;
        win_we   = m2_we_i;
        win_rd   = m2_rd_i;
        case (win_idx)
            2'd0: begin win_addr = m0_addr_i; win_data = m0_data_i; win_we = m0_we_i; win_rd = m0_rd_i; end
            2'd1: begin win_addr = m1_addr_i; win_data = m1_data_i; win_we = m1_we_i; win_rd = m1_rd_i; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= SKIP_INIT ? S_IDLE : S_INIT;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_INIT:  if (ctrl_ack_i) next_state = S_IDLE;
            S_IDLE:  if (any_req)    next_state = S_ISSUE;
            S_ISSUE: if (ctrl_ack_i) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_INIT;
        endcase
    end

    // Strobes drop on the ack edge so the controller never sees a stale request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_addr_o <= '0;
            ctrl_data_o <= '0;
            ctrl_we_o   <= 1'b0;
            ctrl_rd_o   <= 1'b0;
            grant_o     <= 3'b000;
            m0_data_o   <= '0;
            m1_data_o   <= '0;
            m2_data_o   <= '0;
            m0_ack_o    <= 1'b0;
            m1_ack_o    <= 1'b0;
            m2_ack_o    <= 1'b0;
        end else begin
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m2_ack_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        ctrl_addr_o <= win_addr;
                        ctrl_data_o <= win_data;
                        ctrl_we_o   <= win_we;
                        ctrl_rd_o   <= win_rd & ~win_we;
                        grant_o     <= win;
                    end
                end
                S_ISSUE: begin
                    if (ctrl_ack_i) begin
                        ctrl_we_o <= 1'b0;
                        ctrl_rd_o <= 1'b0;
                        if (grant_o[0]) begin m0_data_o <= ctrl_data_i; m0_ack_o <= 1'b1; end
                        if (grant_o[1]) begin m1_data_o <= ctrl_data_i; m1_ack_o <= 1'b1; end
                        if (grant_o[2]) begin m2_data_o <= ctrl_data_i; m2_ack_o <= 1'b1; end
                    end
                end
                S_RESP:  grant_o <= 3'b000;
                default: ;
            endcase
        end
    end

endmodule
